// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage bubble/flush, EX forwarding select, D-cache miss hold with watchdog.
// Optional HAZARD_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
   parameter int MISS_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] reg1_src_ID,
   input  logic [4:0] reg2_src_ID,
   input  logic [1:0] src_en_ID,
   input  logic [4:0] reg1_src_EX,
   input  logic [4:0] reg2_src_EX,
   input  logic [4:0] reg_dest_EX,
   input  logic       load_EX,
   input  logic       br_EX,
   input  logic       jal_ID,
   input  logic [4:0] reg_dest_MEM,
   input  logic [4:0] reg_dest_WB,
   input  logic       reg_write_en_MEM,
   input  logic       reg_write_en_WB,
   input  logic       dcache_miss_MEM,
   input  logic       dcache_ready,
   output logic       bubbleF,
   output logic       bubbleD,
   output logic       bubbleE,
   output logic       bubbleM,
   output logic       bubbleW,
   output logic       flushF,
   output logic       flushD,
   output logic       flushE,
   output logic       flushM,
   output logic       flushW,
   output logic [1:0] op1_sel,
   output logic [1:0] op2_sel,
   output logic       miss_timeout
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   // state | meaning
   // RUN   | pipeline flowing; a miss in MEM stalls this cycle and enters MISS
   // MISS  | whole pipeline held until dcache_ready is sampled
   typedef enum logic {RUN = 1'b0, MISS = 1'b1} state_t;

   localparam logic [15:0] TIMEOUT_LIM = 16'(MISS_TIMEOUT);

   state_t      state;
   logic [15:0] miss_cnt;
   logic        stall;
   logic        load_use;

   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       wen_mem,
                                          input logic [4:0] dest_mem,
                                          input logic       wen_wb,
                                          input logic [4:0] dest_wb);
      if (wen_mem && dest_mem != 5'd0 && dest_mem == src)
         return 2'b01;
      else if (wen_wb && dest_wb != 5'd0 && dest_wb == src)
         return 2'b10;
      else
         return 2'b00;
   endfunction

   assign op1_sel = fwd_sel(reg1_src_EX, reg_write_en_MEM, reg_dest_MEM,
                            reg_write_en_WB, reg_dest_WB);
   assign op2_sel = fwd_sel(reg2_src_EX, reg_write_en_MEM, reg_dest_MEM,
                            reg_write_en_WB, reg_dest_WB);

   assign load_use = load_EX && (reg_dest_EX != 5'd0) &&
                     ((src_en_ID[0] && reg1_src_ID == reg_dest_EX) ||
                      (src_en_ID[1] && reg2_src_ID == reg_dest_EX));

   // Mealy term lets the miss cycle itself hold before the FSM registers it.
   assign stall = (state == MISS) || dcache_miss_MEM;

   // Stall wins over everything; a taken branch squashes the load-use hold.
   assign bubbleF = stall || (load_use && !br_EX);
   assign bubbleD = stall || (load_use && !br_EX);
   assign bubbleE = stall;
   assign bubbleM = stall;
   assign bubbleW = stall;

   assign flushF = 1'b0;
   assign flushD = !stall && (br_EX || jal_ID);
   assign flushE = !stall && (br_EX || load_use);
   assign flushM = 1'b0;
   assign flushW = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         miss_cnt     <= '0;
         miss_timeout <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (dcache_miss_MEM) begin
                  state    <= MISS;
                  miss_cnt <= '0;
               end
            end
            MISS: begin
               if (dcache_ready)
                  state <= RUN;
               // Counter freezes once the sticky flag is up, so it never wraps.
               if (!miss_timeout) begin
                  miss_cnt <= miss_cnt + 16'd1;
                  if (miss_cnt + 16'd1 == TIMEOUT_LIM)
                     miss_timeout <= 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (bubbleF)
            stall_cnt <= stall_cnt + 32'd1;
         if (flushD)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_hazard_ctrl;

   localparam int TIMEOUT = 4;

   logic       clk;
   logic       rst_n;
   logic [4:0] reg1_src_ID, reg2_src_ID, reg1_src_EX, reg2_src_EX;
   logic [4:0] reg_dest_EX, reg_dest_MEM, reg_dest_WB;
   logic [1:0] src_en_ID;
   logic       load_EX, br_EX, jal_ID;
   logic       reg_write_en_MEM, reg_write_en_WB;
   logic       dcache_miss_MEM, dcache_ready;
   logic       bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
   logic       flushF, flushD, flushE, flushM, flushW;
   logic [1:0] op1_sel, op2_sel;
   logic       miss_timeout;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   hazard_ctrl #(.MISS_TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .reg1_src_ID(reg1_src_ID), .reg2_src_ID(reg2_src_ID), .src_en_ID(src_en_ID),
      .reg1_src_EX(reg1_src_EX), .reg2_src_EX(reg2_src_EX), .reg_dest_EX(reg_dest_EX),
      .load_EX(load_EX), .br_EX(br_EX), .jal_ID(jal_ID),
      .reg_dest_MEM(reg_dest_MEM), .reg_dest_WB(reg_dest_WB),
      .reg_write_en_MEM(reg_write_en_MEM), .reg_write_en_WB(reg_write_en_WB),
      .dcache_miss_MEM(dcache_miss_MEM), .dcache_ready(dcache_ready),
      .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM), .bubbleW(bubbleW),
      .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .op1_sel(op1_sel), .op2_sel(op2_sel), .miss_timeout(miss_timeout)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: "inside a miss" flag, count of whole cycles spent in it, sticky timeout.
   bit          m_in_miss;
   int          m_miss_cycles;
   bit          m_timeout;
   int unsigned m_stalls, m_flushes;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] exp_fwd(input logic [4:0] src);
      if (reg_write_en_MEM && reg_dest_MEM != 0 && reg_dest_MEM == src) return 2'b01;
      if (reg_write_en_WB && reg_dest_WB != 0 && reg_dest_WB == src) return 2'b10;
      return 2'b00;
   endfunction

   function automatic bit exp_stall();
      return m_in_miss || dcache_miss_MEM;
   endfunction

   function automatic bit exp_load_use();
      if (!load_EX || reg_dest_EX == 0) return 0;
      return (src_en_ID[0] && reg1_src_ID == reg_dest_EX) ||
             (src_en_ID[1] && reg2_src_ID == reg_dest_EX);
   endfunction

   // {F,D,E,M,W}
   function automatic logic [4:0] exp_bubbles();
      if (exp_stall()) return 5'b11111;
      if (exp_load_use() && !br_EX) return 5'b11000;
      return 5'b00000;
   endfunction

   function automatic logic [4:0] exp_flushes();
      if (exp_stall()) return 5'b00000;
      return {1'b0, br_EX || jal_ID, br_EX || exp_load_use(), 2'b00};
   endfunction

   task automatic model_reset();
      m_in_miss = 0; m_miss_cycles = 0; m_timeout = 0;
      m_stalls = 0; m_flushes = 0;
   endtask

   task automatic model_clock();
      logic [4:0] b, f;
      b = exp_bubbles();
      f = exp_flushes();
      if (b[4]) m_stalls++;
      if (f[3]) m_flushes++;
      if (!m_in_miss) begin
         if (dcache_miss_MEM) begin
            m_in_miss = 1;
            m_miss_cycles = 0;
         end
      end else begin
         m_miss_cycles++;
         if (m_miss_cycles >= TIMEOUT) m_timeout = 1;
         if (dcache_ready) m_in_miss = 0;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".op1"}, 32'(op1_sel), 32'(exp_fwd(reg1_src_EX)));
      chk({tag, ".op2"}, 32'(op2_sel), 32'(exp_fwd(reg2_src_EX)));
      chk({tag, ".bub"}, 32'({bubbleF, bubbleD, bubbleE, bubbleM, bubbleW}), 32'(exp_bubbles()));
      chk({tag, ".fl"}, 32'({flushF, flushD, flushE, flushM, flushW}), 32'(exp_flushes()));
      chk({tag, ".to"}, 32'(miss_timeout), 32'(m_timeout));
`ifdef HAZARD_PERF_CNT_EN
      chk({tag, ".scnt"}, stall_cnt, m_stalls);
      chk({tag, ".fcnt"}, flush_cnt, m_flushes);
`endif
   endtask

   task automatic clear_inputs();
      reg1_src_ID = 0; reg2_src_ID = 0; src_en_ID = 0;
      reg1_src_EX = 0; reg2_src_EX = 0; reg_dest_EX = 0;
      load_EX = 0; br_EX = 0; jal_ID = 0;
      reg_dest_MEM = 0; reg_dest_WB = 0;
      reg_write_en_MEM = 0; reg_write_en_WB = 0;
      dcache_miss_MEM = 0; dcache_ready = 0;
   endtask

   // Inputs are applied at posedge+1; outputs sampled at posedge+3.
   task automatic settle(input string tag);
      #2;
      check_model(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      settle("rst");
      #1 rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "time budget exceeded");
   end

   initial begin
      do_reset();

      // Forwarding
      reg1_src_EX = 5; reg2_src_EX = 6;
      reg_write_en_MEM = 1; reg_dest_MEM = 5; reg_write_en_WB = 1; reg_dest_WB = 5;
      settle("fwd_both");
      chk("fwd_both_op1", 32'(op1_sel), 32'd1);
      tick();
      reg_dest_MEM = 0;
      settle("fwd_x0mem");
      chk("fwd_x0mem_op1", 32'(op1_sel), 32'd2);
      tick();
      reg1_src_EX = 0; reg_dest_WB = 0; reg_write_en_WB = 1;
      settle("fwd_x0");
      chk("fwd_x0_op1", 32'(op1_sel), 32'd0);
      tick();
      clear_inputs();
      reg1_src_EX = 5; reg2_src_EX = 5; reg_write_en_WB = 1; reg_dest_WB = 5;
      reg_write_en_MEM = 0; reg_dest_MEM = 5;
      settle("fwd_wb");
      chk("fwd_wb_op1", 32'(op1_sel), 32'd2);
      chk("fwd_wb_op2", 32'(op2_sel), 32'd2);
      tick();

      // Load-use
      clear_inputs();
      load_EX = 1; reg_dest_EX = 7; reg2_src_ID = 7; src_en_ID = 2'b10;
      settle("lu");
      chk("lu_bub", 32'({bubbleF, bubbleD, flushE}), 32'b111);
      tick();
      src_en_ID = 2'b01;
      settle("lu_noen");
      chk("lu_noen_bub", 32'({bubbleF, bubbleD, flushE}), 32'b000);
      tick();

      // Redirects
      src_en_ID = 2'b10; br_EX = 1;
      settle("br_lu");
      chk("br_lu_v", 32'({flushD, flushE, bubbleF, bubbleD}), 32'b1100);
      tick();
      clear_inputs();
      jal_ID = 1;
      settle("jal");
      chk("jal_fl", 32'({flushF, flushD, flushE, flushM, flushW}), 32'b01000);
      chk("jal_bub", 32'({bubbleF, bubbleD, bubbleE, bubbleM, bubbleW}), 32'b0);
      tick();

      // Miss: pulse at cycle 0, ready at cycle 5, branch held throughout
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         clear_inputs();
         dcache_miss_MEM = (c == 0);
         dcache_ready    = (c == 5);
         br_EX           = (c <= 5);
         settle($sformatf("miss_c%0d", c));
         chk($sformatf("miss_bub_c%0d", c), 32'({bubbleF, bubbleD, bubbleE, bubbleM, bubbleW}),
             (c <= 5) ? 32'b11111 : 32'b0);
         chk($sformatf("miss_fl_c%0d", c), 32'({flushF, flushD, flushE, flushM, flushW}), 32'b0);
`ifdef HAZARD_PERF_CNT_EN
         if (c == 6) chk("perf_stall6", stall_cnt, 32'd6);
`endif
         tick();
      end
      clear_inputs();
      for (int c = 0; c < 3; c++) begin
         br_EX = (c < 2); jal_ID = (c == 2);
         settle($sformatf("redir_c%0d", c));
         tick();
      end
      clear_inputs();
      settle("redir_done");
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_flush3", flush_cnt, 32'd3);
`endif
      tick();

      // Watchdog with no ready, then async reset mid-miss
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         clear_inputs();
         dcache_miss_MEM = (c == 0);
         settle($sformatf("wd_c%0d", c));
         if (c == 4) chk("wd_before", 32'(miss_timeout), 32'd0);
         if (c >= 5) chk($sformatf("wd_set_c%0d", c), 32'(miss_timeout), 32'd1);
         if (c < 6) tick();
      end
      rst_n = 1'b0;
      #1;
      chk("arst_bub", 32'({bubbleF, bubbleD, bubbleE, bubbleM, bubbleW}), 32'b0);
      chk("arst_to", 32'(miss_timeout), 32'd0);
      model_reset();
      #1 rst_n = 1'b1;
      tick();

      // Random traffic, periodically re-reset so the watchdog and FSM are re-exercised
      for (int blk = 0; blk < 8; blk++) begin
         do_reset();
         for (int c = 0; c < 250; c++) begin
            reg1_src_ID      = 5'($urandom_range(0, 3));
            reg2_src_ID      = 5'($urandom_range(0, 3));
            src_en_ID        = 2'($urandom_range(0, 3));
            reg1_src_EX      = 5'($urandom_range(0, 3));
            reg2_src_EX      = 5'($urandom_range(0, 3));
            reg_dest_EX      = 5'($urandom_range(0, 3));
            reg_dest_MEM     = 5'($urandom_range(0, 3));
            reg_dest_WB      = 5'($urandom_range(0, 3));
            reg_write_en_MEM = 1'($urandom_range(0, 1));
            reg_write_en_WB  = 1'($urandom_range(0, 1));
            load_EX          = ($urandom_range(0, 2) == 0);
            br_EX            = ($urandom_range(0, 5) == 0);
            jal_ID           = ($urandom_range(0, 5) == 0);
            dcache_miss_MEM  = ($urandom_range(0, 11) == 0);
            dcache_ready     = ($urandom_range(0, 3 + blk) == 0);
            settle("rnd");
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
